// File: rtl/fifo_ctrl_amisha_pkg.sv
// Shared constants and the push/pop op-code for the FIFO pointer/flag controller.
package fifo_pkg_amisha;

    localparam int W_DEF_AMISHA      = 2;
    localparam int AF_LVL_DEF_AMISHA = 3;

    // Encoded as {push_ok, pop_ok} so the decode is a plain cast.
    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } op_e;

endpackage

// File: rtl/fifo_ctrl_amisha_if.sv
// Handshake/status bundle between the FIFO wrapper and its pointer/flag controller.
// Optional ovf/udf status appears only when FIFO_CTRL_ERR_FLAG_EN is defined.
interface fifo_ctrl_amisha_if #(
    parameter int W_amisha = fifo_pkg_amisha::W_DEF_AMISHA
);
    logic                wr_amisha;
    logic                rd_amisha;
    logic                wr_en_amisha;
    logic [W_amisha-1:0] w_addr_amisha;
    logic [W_amisha-1:0] r_addr_amisha;
    logic                empty_amisha;
    logic                full_amisha;
    logic                almost_full_amisha;
    logic [W_amisha:0]   count_amisha;
`ifdef FIFO_CTRL_ERR_FLAG_EN
    logic                ovf_amisha;
    logic                udf_amisha;
`endif

    modport slave (
        input  wr_amisha, rd_amisha,
        output wr_en_amisha, w_addr_amisha, r_addr_amisha,
               empty_amisha, full_amisha, almost_full_amisha, count_amisha
`ifdef FIFO_CTRL_ERR_FLAG_EN
        , output ovf_amisha, udf_amisha
`endif
    );

    modport master (
        output wr_amisha, rd_amisha,
        input  wr_en_amisha, w_addr_amisha, r_addr_amisha,
               empty_amisha, full_amisha, almost_full_amisha, count_amisha
`ifdef FIFO_CTRL_ERR_FLAG_EN
        , input ovf_amisha, udf_amisha
`endif
    );

endinterface

// File: rtl/fifo_ptr_amisha.sv
// W-bit wrapping pointer register with increment enable; D-1 wraps to 0 naturally.
module fifo_ptr_amisha #(
    parameter int W_amisha = fifo_pkg_amisha::W_DEF_AMISHA
) (
    input  logic                clk_amisha,
    input  logic                rst_n_amisha,
    input  logic                inc_amisha,
    output logic [W_amisha-1:0] ptr_amisha
);

    logic [W_amisha-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc_amisha) ptr_d = ptr_q + W_amisha'(1);
    end

    always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
        if (!rst_n_amisha) ptr_q <= '0;
        else               ptr_q <= ptr_d;
    end

    assign ptr_amisha = ptr_q;

endmodule

// File: rtl/fifo_ctrl_amisha.sv
// Pointer/flag controller that turns a 2**W register file into a synchronous FIFO.
// Define FIFO_CTRL_ERR_FLAG_EN to add sticky overflow/underflow flags.
module fifo_ctrl_amisha
    import fifo_pkg_amisha::*;
#(
    parameter int W_amisha      = W_DEF_AMISHA,
    parameter int AF_LVL_amisha = AF_LVL_DEF_AMISHA
) (
    input  logic             clk_amisha,
    input  logic             rst_n_amisha,
    fifo_ctrl_amisha_if.slave bus
);

    localparam logic [W_amisha:0] DEPTH = (W_amisha+1)'(2**W_amisha);
    localparam logic [W_amisha:0] AF_LVL = (W_amisha+1)'(AF_LVL_amisha);

    logic [W_amisha:0]   count_q, count_d;
    logic                empty_q, empty_d;
    logic                full_q,  full_d;
    logic                push_ok, pop_ok;
    logic [W_amisha-1:0] w_ptr, r_ptr;
    op_e                 op;

    // A push into a full FIFO is legal when the same cycle frees a slot.
    assign push_ok = bus.wr_amisha & (~full_q | bus.rd_amisha);
    assign pop_ok  = bus.rd_amisha & ~empty_q;
    assign op      = op_e'({push_ok, pop_ok});

    always_comb begin
        count_d = count_q;
        empty_d = empty_q;
        full_d  = full_q;
        case (op)
            OP_PUSH: begin
                count_d = count_q + (W_amisha+1)'(1);
                empty_d = 1'b0;
                full_d  = (count_d == DEPTH);
            end
            OP_POP: begin
                count_d = count_q - (W_amisha+1)'(1);
                full_d  = 1'b0;
                empty_d = (count_d == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
        if (!rst_n_amisha) begin
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    fifo_ptr_amisha #(.W_amisha(W_amisha)) u_w_ptr (
        .clk_amisha   (clk_amisha),
        .rst_n_amisha (rst_n_amisha),
        .inc_amisha   (push_ok),
        .ptr_amisha   (w_ptr)
    );

    fifo_ptr_amisha #(.W_amisha(W_amisha)) u_r_ptr (
        .clk_amisha   (clk_amisha),
        .rst_n_amisha (rst_n_amisha),
        .inc_amisha   (pop_ok),
        .ptr_amisha   (r_ptr)
    );

    assign bus.wr_en_amisha       = push_ok;
    assign bus.w_addr_amisha      = w_ptr;
    assign bus.r_addr_amisha      = r_ptr;
    assign bus.empty_amisha       = empty_q;
    assign bus.full_amisha        = full_q;
    assign bus.count_amisha       = count_q;
    assign bus.almost_full_amisha = (count_q >= AF_LVL);

`ifdef FIFO_CTRL_ERR_FLAG_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    always_comb begin
        ovf_d = ovf_q | (bus.wr_amisha & full_q & ~bus.rd_amisha);
        udf_d = udf_q | (bus.rd_amisha & empty_q);
    end

    always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
        if (!rst_n_amisha) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign bus.ovf_amisha = ovf_q;
    assign bus.udf_amisha = udf_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl_amisha.sv
// Self-checking bench: occupancy model plus a data scoreboard against a register file model.
module tb_fifo_ctrl_amisha;
    import fifo_pkg_amisha::*;

    localparam int W  = 2;
    localparam int D  = 4;
    localparam int AF = 3;

    logic clk_amisha = 1'b0;
    logic rst_n_amisha = 1'b0;

    fifo_ctrl_amisha_if #(.W_amisha(W)) bus ();

    fifo_ctrl_amisha #(.W_amisha(W), .AF_LVL_amisha(AF)) dut (
        .clk_amisha   (clk_amisha),
        .rst_n_amisha (rst_n_amisha),
        .bus          (bus)
    );

    always #5 clk_amisha = ~clk_amisha;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference state
    int m_count, m_w, m_r;
    bit m_ovf, m_udf;
    logic [7:0] rf_mem [D];
    logic [7:0] exp_q [$];
    logic [7:0] next_data = 8'h10;

    task automatic check_val(input string tag, input int act, input int exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_w = 0; m_r = 0;
        m_ovf = 1'b0; m_udf = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_state(input string tag);
        check_val({tag, ".count"}, int'(bus.count_amisha), m_count);
        check_val({tag, ".w_addr"}, int'(bus.w_addr_amisha), m_w);
        check_val({tag, ".r_addr"}, int'(bus.r_addr_amisha), m_r);
        check_val({tag, ".empty"}, int'(bus.empty_amisha), int'(m_count == 0));
        check_val({tag, ".full"}, int'(bus.full_amisha), int'(m_count == D));
        check_val({tag, ".afull"}, int'(bus.almost_full_amisha), int'(m_count >= AF));
`ifdef FIFO_CTRL_ERR_FLAG_EN
        check_val({tag, ".ovf"}, int'(bus.ovf_amisha), int'(m_ovf));
        check_val({tag, ".udf"}, int'(bus.udf_amisha), int'(m_udf));
`endif
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic step(input string tag, input bit wr, input bit rd);
        bit exp_push, exp_pop, we;
        logic [W-1:0] wa;
        logic [7:0] got, want;
        bus.wr_amisha = wr;
        bus.rd_amisha = rd;
        exp_push = wr && ((m_count != D) || rd);
        exp_pop  = rd && (m_count != 0);
        #1;
        check_val({tag, ".wr_en"}, int'(bus.wr_en_amisha), int'(exp_push));
        we = bus.wr_en_amisha;
        wa = bus.w_addr_amisha;
        if (exp_pop) begin
            got  = rf_mem[bus.r_addr_amisha];
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            check_val({tag, ".rdata"}, int'(got), int'(want));
        end
        if (exp_push) exp_q.push_back(next_data);
        @(posedge clk_amisha);
        if (we) rf_mem[wa] = next_data;
        if (exp_push) next_data = next_data + 8'd1;
        if (wr && m_count == D && !rd) m_ovf = 1'b1;
        if (rd && m_count == 0) m_udf = 1'b1;
        if (exp_push) m_w = (m_w + 1) % D;
        if (exp_pop)  m_r = (m_r + 1) % D;
        m_count = m_count + int'(exp_push) - int'(exp_pop);
        #1;
        check_state(tag);
        $display("step %s wr=%0b rd=%0b count=%0d w=%0d r=%0d", tag, wr, rd,
                 bus.count_amisha, bus.w_addr_amisha, bus.r_addr_amisha);
    endtask

    initial begin
        for (int i = 0; i < D; i++) rf_mem[i] = 8'h00;
        bus.wr_amisha = 1'b0;
        bus.rd_amisha = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_amisha);
        #1 rst_n_amisha = 1'b1;
        check_state("reset");
        check_val("reset.wr_en", int'(bus.wr_en_amisha), 0);
        step("idle", 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) step($sformatf("push%0d", i), 1'b1, 1'b0);
        step("push_full", 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step($sformatf("both_full%0d", i), 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step($sformatf("drain%0d", i), 1'b0, 1'b1);

        step("empty_both", 1'b1, 1'b1);
        step("pop1", 1'b0, 1'b1);
        step("pop_empty", 1'b0, 1'b1);

        for (int i = 0; i < 6; i++) begin
            step($sformatf("il_push%0d", i), 1'b1, 1'b0);
            step($sformatf("il_pop%0d", i), 1'b0, 1'b1);
        end
        step("il_both", 1'b1, 1'b1);
        step("il_pop_last", 1'b0, 1'b1);

        step("pre_rst0", 1'b1, 1'b0);
        step("pre_rst1", 1'b1, 1'b0);
        check_val("pre_rst.count", int'(bus.count_amisha), 2);
        // Mid-cycle reset: the wrapper gates wr with rst_n.
        #2;
        rst_n_amisha = 1'b0;
        bus.wr_amisha = 1'b0;
        bus.rd_amisha = 1'b0;
        model_reset();
        #1;
        check_state("async_rst");
        check_val("async_rst.wr_en", int'(bus.wr_en_amisha), 0);
        @(posedge clk_amisha);
        #1 rst_n_amisha = 1'b1;
        check_state("post_rst");
        step("post_rst_push", 1'b1, 1'b0);
        step("post_rst_pop", 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
